// File: rtl/pulse_burst_ctrl.sv
// Pulse-burst sequencer: delay, then nburst pulses of width tw every tp cycles.
// Optional macro PULSE_BURST_CONT_EN makes nburst==0 a legal continuous-run request.
module pulse_burst_ctrl #(
  parameter int unsigned CW = 16,
  parameter int unsigned NW = 8,
  parameter logic        B0 = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [CW-1:0] td,
  input  logic [CW-1:0] tw,
  input  logic [CW-1:0] tp,
  input  logic [NW-1:0] nburst,
  output logic          out,
  output logic          outb,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  output logic [NW-1:0] pcnt
);

  typedef enum logic [1:0] {IDLE, DELAY, ACT, INACT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] lat_tw, lat_tw_n;
  logic [CW-1:0] lat_ti, lat_ti_n;
  logic [NW-1:0] lat_n, lat_n_n;
  logic          out_n, busy_n, done_n, cfg_err_n;
  logic [NW-1:0] pcnt_n;
  logic          nb_bad, cfg_bad, last, cnt_zero;
  logic [NW-1:0] pcnt_inc;

`ifdef PULSE_BURST_CONT_EN
  assign nb_bad = 1'b0;
`else
  assign nb_bad = (nburst == '0);
`endif

  assign cfg_bad  = (tw == '0) || (tw >= tp) || nb_bad;
  // lat_n==0 only exists in continuous mode, which never ends on its own
  assign last     = (lat_n != '0) && (pcnt == lat_n);
  assign cnt_zero = (cnt == '0);
  assign pcnt_inc = (pcnt == {NW{1'b1}}) ? pcnt : pcnt + NW'(1);
  assign outb     = ~out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      lat_tw  <= '0;
      lat_ti  <= '0;
      lat_n   <= '0;
      out     <= B0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      pcnt    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      lat_tw  <= lat_tw_n;
      lat_ti  <= lat_ti_n;
      lat_n   <= lat_n_n;
      out     <= out_n;
      busy    <= busy_n;
      done    <= done_n;
      cfg_err <= cfg_err_n;
      pcnt    <= pcnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    lat_tw_n  = lat_tw;
    lat_ti_n  = lat_ti;
    lat_n_n   = lat_n;
    out_n     = out;
    busy_n    = busy;
    done_n    = 1'b0;
    cfg_err_n = 1'b0;
    pcnt_n    = pcnt;
    // any busy state: stop aborts with no done and pcnt held
    if (state != IDLE && stop) begin
      state_n = IDLE;
      out_n   = B0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !stop) begin
            if (cfg_bad) begin
              cfg_err_n = 1'b1;
            end else begin
              lat_tw_n = tw;
              lat_ti_n = tp - tw;
              lat_n_n  = nburst;
              cnt_n    = td;
              pcnt_n   = '0;
              busy_n   = 1'b1;
              state_n  = DELAY;
            end
          end
        end
        DELAY, INACT: begin
          if (cnt_zero) begin
            state_n = ACT;
            out_n   = ~B0;
            pcnt_n  = pcnt_inc;
            cnt_n   = lat_tw - CW'(1);
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        ACT: begin
          if (cnt_zero) begin
            out_n = B0;
            if (last) begin
              state_n = IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = INACT;
              cnt_n   = lat_ti - CW'(1);
            end
          end else begin
            cnt_n = cnt - CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_burst_ctrl.sv
// Scoreboarded bench for pulse_burst_ctrl: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pulse_burst_ctrl;

  localparam int unsigned CW = 16;
  localparam int unsigned NW = 8;
  localparam logic        B0 = 1'b0;
  localparam int          PMAX = (1 << NW) - 1;

  typedef struct {
    int cyc;
    int tid;
    bit act;
    bit busy;
    bit done;
    bit cerr;
    int pcnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [CW-1:0] td = '0, tw = '0, tp = '0;
  logic [NW-1:0] nburst = '0;
  logic          out, outb, busy, done, cfg_err;
  logic [NW-1:0] pcnt;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tid = 0;
  bit   req_end = 1'b0;
  exp_t q[$];

  pulse_burst_ctrl #(.CW(CW), .NW(NW), .B0(B0)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .td(td), .tw(tw), .tp(tp), .nburst(nburst),
    .out(out), .outb(outb), .busy(busy), .done(done),
    .cfg_err(cfg_err), .pcnt(pcnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  function automatic int npulses(input int k, input int first, input int per);
    return (k < first) ? 0 : (k - first) / per + 1;
  endfunction

  task automatic push_idle(input int k, input int pc, input bit cerr);
    exp_t e;
    e.cyc = k; e.tid = tid; e.act = 1'b0; e.busy = 1'b0;
    e.done = 1'b0; e.cerr = cerr; e.pcnt = pc;
    q.push_back(e);
  endtask

  // Expected waveform from the timing formulas: pulse i starts at edge e0+td+1+i*tp
  task automatic push_burst(input int e0, input int d, input int w, input int p,
                            input int n, input int cut, input bit cut_rst, input int nidle);
    int   first, last_end, stop_k, held;
    exp_t e;
    first    = e0 + d + 1;
    last_end = (n == 0) ? 32'h3fff_ffff : first + (n - 1) * p + w;
    stop_k   = (cut >= 0) ? cut : last_end;
    held     = cut_rst ? 0 : sat(npulses(stop_k - 1, first, p));
    for (int k = e0; k <= stop_k + nidle; k++) begin
      e.cyc = k; e.tid = tid; e.cerr = 1'b0;
      if (k < stop_k) begin
        e.busy = 1'b1;
        e.done = 1'b0;
        e.act  = (k >= first) && (((k - first) % p) < w);
        e.pcnt = sat(npulses(k, first, p));
      end else begin
        e.busy = 1'b0;
        e.act  = 1'b0;
        e.done = (cut < 0) && (k == last_end);
        e.pcnt = held;
      end
      q.push_back(e);
    end
  endtask

  // Drives a start at the current negedge; the start is accepted at edge e0
  task automatic launch(input int d, input int w, input int p, input int n, output int e0);
    @(negedge clk);
    td = CW'(d); tw = CW'(w); tp = CW'(p); nburst = NW'(n);
    start = 1'b1;
    e0 = cyc + 1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
  endtask

  // Monitor: every cycle is an output presentation; pop the matching expectation
  always @(negedge clk) begin
    exp_t e;
    logic exp_out;
    if (cyc > 0) begin
      checks++;
      if (outb !== ~out) begin
        errors++;
        $display("FAIL outb_inverse cyc=%0d out=%b outb=%b", cyc, out, outb);
      end
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_sample t%0d cyc=%0d expected at cyc %0d", e.tid, cyc, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e = q.pop_front();
      exp_out = e.act ? ~B0 : B0;
      checks++;
      if (out !== exp_out || busy !== e.busy || done !== e.done ||
          cfg_err !== e.cerr || pcnt !== NW'(e.pcnt)) begin
        errors++;
        $display("FAIL t%0d cyc=%0d got out=%b busy=%b done=%b cfg_err=%b pcnt=%0d want out=%b busy=%b done=%b cfg_err=%b pcnt=%0d",
                 e.tid, cyc, out, busy, done, cfg_err, pcnt,
                 exp_out, e.busy, e.done, e.cerr, e.pcnt);
      end
    end else if (cyc > 0 && (done === 1'b1 || cfg_err === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_strobe cyc=%0d done=%b cfg_err=%b want both 0", cyc, done, cfg_err);
    end
    if (req_end) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL scoreboard_drain left=%0d want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  initial begin
    int e0;
    int c;
    // reset held over edges 1..3; values checked at edge 3
    tid = 0;
    repeat (2) @(negedge clk);
    push_idle(cyc + 1, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    push_idle(cyc + 1, 0, 1'b0);
    drain();

    // T1: delayed two-pulse burst
    tid = 1;
    launch(2, 3, 5, 2, e0);
    push_burst(e0, 2, 3, 5, 2, -1, 1'b0, 2);
    @(negedge clk); start = 1'b0;
    drain();

    // T2: zero delay, toggling every cycle
    tid = 2;
    launch(0, 1, 2, 4, e0);
    push_burst(e0, 0, 1, 2, 4, -1, 1'b0, 2);
    @(negedge clk); start = 1'b0;
    drain();

    // T3: illegal configs, pcnt keeps 4 from T2
    tid = 3;
    launch(0, 4, 4, 1, e0);
    push_idle(e0, 4, 1'b1); push_idle(e0 + 1, 4, 1'b0);
    @(negedge clk); start = 1'b0;
    launch(0, 0, 2, 1, e0);
    push_idle(e0, 4, 1'b1); push_idle(e0 + 1, 4, 1'b0);
    @(negedge clk); start = 1'b0;
`ifndef PULSE_BURST_CONT_EN
    launch(0, 1, 2, 0, e0);
    push_idle(e0, 4, 1'b1); push_idle(e0 + 1, 4, 1'b0);
    @(negedge clk); start = 1'b0;
`endif
    drain();

    // T4: stop during the 3rd pulse, ignored start mid-burst
    tid = 4;
    launch(1, 3, 6, 5, e0);
    push_burst(e0, 1, 3, 6, 5, e0 + 15, 1'b0, 2);
    @(negedge clk); start = 1'b0;
    wait_until(e0 + 4);
    td = '0; tw = CW'(1); tp = CW'(2); nburst = NW'(1); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_until(e0 + 14);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    drain();

    // T5: reset mid-INACT, then start+stop in the same cycle
    tid = 5;
    launch(0, 2, 5, 3, e0);
    push_burst(e0, 0, 2, 5, 3, e0 + 4, 1'b1, 2);
    @(negedge clk); start = 1'b0;
    wait_until(e0 + 3);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    drain();
    @(negedge clk);
    c = cyc;
    tw = CW'(1); tp = CW'(2); nburst = NW'(1); start = 1'b1; stop = 1'b1;
    push_idle(c + 1, 0, 1'b0); push_idle(c + 2, 0, 1'b0);
    @(negedge clk); start = 1'b0; stop = 1'b0;
    drain();

`ifdef PULSE_BURST_CONT_EN
    // T6: continuous run past pcnt saturation, ended by stop
    tid = 6;
    launch(0, 2, 3, 0, e0);
    push_burst(e0, 0, 2, 3, 0, e0 + 950, 1'b0, 2);
    @(negedge clk); start = 1'b0;
    wait_until(e0 + 949);
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    drain();
`endif

    req_end = 1'b1;
  end

endmodule
